// File: rtl/udp_axi_cmd_bridge.sv
// UDP payload command parser driving an AXI-style burst master; read data
// is buffered and returned to the UDP transmitter as a response packet.
module udp_axi_cmd_bridge #(
    parameter int         BUF_DEPTH = 256,
    parameter logic [7:0] OP_WR     = 8'h01,
    parameter logic [7:0] OP_RD     = 8'h02
) (
    input  logic        gmii_rx_clk,
    input  logic        rst,
    input  logic [31:0] datain,
    input  logic        rec_en,
    input  logic        rec_pkt_done,
    input  logic        tx_req,
    output logic        tx_start_en,
    output logic [31:0] udp_tx_data,
    output logic [27:0] wr_addr,
    output logic [7:0]  wr_len,
    output logic        wr_addr_valid,
    input  logic        wr_addr_ready,
    output logic [31:0] wr_data,
    output logic [3:0]  wr_strb,
    output logic        wr_data_valid,
    input  logic        wr_data_ready,
    output logic        wr_data_last,
    output logic [27:0] rd_addr,
    output logic [7:0]  rd_len,
    output logic        rd_addr_valid,
    input  logic        rd_addr_ready,
    input  logic [31:0] rd_data,
    input  logic        rd_data_last,
    output logic        rd_data_ready,
    input  logic        rd_data_valid
);
    localparam int AW = $clog2(BUF_DEPTH);
    localparam int CW = 12;

    typedef enum logic [2:0] {
        S_IDLE, S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_RD_DATA, S_TX_START, S_TX_DATA
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] word_cnt_q, word_cnt_d, word_inc, cnt_eff;
    logic [7:0]    op_q, op_d, len_q, len_d, beat_q, beat_d;
    logic [27:0]   addr_q, addr_d;
    logic [AW-1:0] rd_idx_q, rd_idx_d;
    logic [8:0]    tx_cnt_q, tx_cnt_d;
    logic [31:0]   tx_data_q, tx_data_d;

    logic [31:0]   buf_mem [BUF_DEPTH];
    logic          mem_we;
    logic [AW-1:0] mem_wa;
    logic [31:0]   mem_wd;

    // Saturate so an oversized packet can never wrap back onto a valid count.
    assign word_inc = (word_cnt_q == '1) ? word_cnt_q : word_cnt_q + CW'(1);

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        op_d       = op_q;
        len_d      = len_q;
        addr_d     = addr_q;
        beat_d     = beat_q;
        rd_idx_d   = rd_idx_q;
        tx_cnt_d   = tx_cnt_q;
        tx_data_d  = tx_data_q;
        mem_we     = 1'b0;
        mem_wa     = '0;
        mem_wd     = '0;
        cnt_eff    = rec_en ? word_inc : word_cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (rec_en) begin
                    word_cnt_d = word_inc;
                    if (word_cnt_q == '0) begin
                        op_d  = datain[31:24];
                        len_d = datain[7:0];
                    end else if (word_cnt_q == CW'(1)) begin
                        addr_d = datain[27:0];
                    end else begin
                        mem_we = 1'b1;
                        mem_wa = AW'(word_cnt_q - CW'(2));
                        mem_wd = datain;
                    end
                end
                // Header words always precede the done cycle for any count that can validate.
                if (rec_pkt_done) begin
                    word_cnt_d = '0;
                    if (op_q == OP_WR && cnt_eff == CW'(len_q) + CW'(3)) begin
                        state_d = S_WR_ADDR;
                        beat_d  = '0;
                    end else if (op_q == OP_RD && cnt_eff == CW'(2)) begin
                        state_d  = S_RD_ADDR;
                        rd_idx_d = '0;
                    end
                end
            end
            S_WR_ADDR: if (wr_addr_ready) state_d = S_WR_DATA;
            S_WR_DATA: begin
                if (wr_data_ready) begin
                    if (beat_q == len_q) state_d = S_IDLE;
                    else                 beat_d  = beat_q + 8'd1;
                end
            end
            S_RD_ADDR: if (rd_addr_ready) state_d = S_RD_DATA;
            S_RD_DATA: begin
                if (rd_data_valid) begin
                    mem_we   = 1'b1;
                    mem_wa   = rd_idx_q;
                    mem_wd   = rd_data;
                    rd_idx_d = rd_idx_q + 1'b1;
                    if (rd_data_last) state_d = S_TX_START;
                end
            end
            S_TX_START: begin
                state_d  = S_TX_DATA;
                tx_cnt_d = '0;
            end
            S_TX_DATA: begin
                if (tx_req) begin
                    tx_data_d = (tx_cnt_q == '0) ? {OP_RD, 16'h0, len_q}
                                                 : buf_mem[AW'(tx_cnt_q - 9'd1)];
                    tx_cnt_d  = tx_cnt_q + 9'd1;
                    if (tx_cnt_q == 9'(len_q) + 9'd1) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge gmii_rx_clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            word_cnt_q <= '0;
            op_q       <= '0;
            len_q      <= '0;
            addr_q     <= '0;
            beat_q     <= '0;
            rd_idx_q   <= '0;
            tx_cnt_q   <= '0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            op_q       <= op_d;
            len_q      <= len_d;
            addr_q     <= addr_d;
            beat_q     <= beat_d;
            rd_idx_q   <= rd_idx_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_data_q  <= tx_data_d;
        end
    end

    // Shared buffer: filled by write payload in IDLE or by read beats in RD_DATA.
    always_ff @(posedge gmii_rx_clk) begin
        if (mem_we) buf_mem[mem_wa] <= mem_wd;
    end

    assign wr_addr       = addr_q;
    assign wr_len        = len_q;
    assign wr_addr_valid = (state_q == S_WR_ADDR);
    assign wr_data_valid = (state_q == S_WR_DATA);
    assign wr_data       = wr_data_valid ? buf_mem[AW'(beat_q)] : '0;
    assign wr_data_last  = wr_data_valid && (beat_q == len_q);
    assign wr_strb       = 4'hF;
    assign rd_addr       = addr_q;
    assign rd_len        = len_q;
    assign rd_addr_valid = (state_q == S_RD_ADDR);
    assign rd_data_ready = (state_q == S_RD_DATA);
    assign tx_start_en   = (state_q == S_TX_START);
    assign udp_tx_data   = tx_data_q;
endmodule

// File: tb/tb_udp_axi_cmd_bridge.sv
// Directed bench for udp_axi_cmd_bridge: a packet vector table plus
// hand-written read-back, backpressure, busy and mid-burst reset sequences.
module tb_udp_axi_cmd_bridge;
    logic        gmii_rx_clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] datain = '0;
    logic        rec_en = 1'b0, rec_pkt_done = 1'b0, tx_req = 1'b0;
    logic        tx_start_en;
    logic [31:0] udp_tx_data, wr_data, rd_data = '0;
    logic [27:0] wr_addr, rd_addr;
    logic [7:0]  wr_len, rd_len;
    logic        wr_addr_valid, wr_addr_ready = 1'b1;
    logic [3:0]  wr_strb;
    logic        wr_data_valid, wr_data_ready = 1'b1, wr_data_last;
    logic        rd_addr_valid, rd_addr_ready = 1'b0;
    logic        rd_data_last = 1'b0, rd_data_ready, rd_data_valid = 1'b0;

    udp_axi_cmd_bridge dut (
        .gmii_rx_clk(gmii_rx_clk), .rst(rst), .datain(datain), .rec_en(rec_en),
        .rec_pkt_done(rec_pkt_done), .tx_req(tx_req), .tx_start_en(tx_start_en),
        .udp_tx_data(udp_tx_data), .wr_addr(wr_addr), .wr_len(wr_len),
        .wr_addr_valid(wr_addr_valid), .wr_addr_ready(wr_addr_ready),
        .wr_data(wr_data), .wr_strb(wr_strb), .wr_data_valid(wr_data_valid),
        .wr_data_ready(wr_data_ready), .wr_data_last(wr_data_last),
        .rd_addr(rd_addr), .rd_len(rd_len), .rd_addr_valid(rd_addr_valid),
        .rd_addr_ready(rd_addr_ready), .rd_data(rd_data), .rd_data_last(rd_data_last),
        .rd_data_ready(rd_data_ready), .rd_data_valid(rd_data_valid)
    );

    always #5 gmii_rx_clk = ~gmii_rx_clk;

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge gmii_rx_clk);
        #1;
    endtask

    // Bus monitor: records handshakes seen at the clock edge.
    int aw_n = 0, ar_n = 0, wbeats = 0, last_n = 0, last_at = 0;
    int early = 0, strb_err = 0, anyv = 0, txs_n = 0;
    logic [27:0] aw_addr_s = '0, ar_addr_s = '0;
    logic [7:0]  aw_len_s = '0, ar_len_s = '0;
    logic [31:0] wdat [4096];
    logic        aw_done;

    always @(posedge gmii_rx_clk) begin
        if (!rst) begin
            if (wr_addr_valid || wr_data_valid || rd_addr_valid || rd_data_ready || tx_start_en)
                anyv <= anyv + 1;
            if (wr_addr_valid && wr_addr_ready) begin
                aw_n <= aw_n + 1; aw_addr_s <= wr_addr; aw_len_s <= wr_len;
            end
            if (wr_data_valid && !aw_done) early <= early + 1;
            if (wr_data_valid && wr_strb != 4'hF) strb_err <= strb_err + 1;
            if (wr_data_valid && wr_data_ready) begin
                wdat[wbeats % 4096] <= wr_data;
                wbeats <= wbeats + 1;
                if (wr_data_last) begin last_n <= last_n + 1; last_at <= wbeats; end
            end
            if (rd_addr_valid && rd_addr_ready) begin
                ar_n <= ar_n + 1; ar_addr_s <= rd_addr; ar_len_s <= rd_len;
            end
            if (tx_start_en) txs_n <= txs_n + 1;
        end
    end

    always @(posedge gmii_rx_clk or posedge rst) begin
        if (rst) aw_done <= 1'b0;
        else if (wr_addr_valid && wr_addr_ready) aw_done <= 1'b1;
        else if (wr_data_valid && wr_data_ready && wr_data_last) aw_done <= 1'b0;
    end

    logic [31:0] pkt_q [$];
    int s_aw, s_ar, s_wb, s_ln, s_early, s_strb, s_anyv, s_txs;

    task automatic snap();
        s_aw = aw_n; s_ar = ar_n; s_wb = wbeats; s_ln = last_n;
        s_early = early; s_strb = strb_err; s_anyv = anyv; s_txs = txs_n;
    endtask

    task automatic build(input logic [7:0] op, input logic [15:0] mid, input logic [7:0] len,
                         input int ndata, input logic [27:0] addr, input logic [31:0] base);
        pkt_q.delete();
        pkt_q.push_back({op, mid, len});
        pkt_q.push_back({4'hA, addr});
        for (int i = 0; i < ndata; i++) pkt_q.push_back(base + 32'(i));
    endtask

    task automatic send_pkt(input bit same_done);
        for (int i = 0; i < pkt_q.size(); i++) begin
            rec_en = 1'b1; datain = pkt_q[i];
            rec_pkt_done = same_done && (i == pkt_q.size() - 1);
            tick();
        end
        rec_en = 1'b0;
        if (!same_done) begin rec_pkt_done = 1'b1; tick(); end
        rec_pkt_done = 1'b0;
    endtask

    task automatic wait_beats(input int target, input int bound);
        for (int k = 0; k < bound && wbeats < target; k++) tick();
    endtask

    task automatic check_wr(input string nm, input logic [27:0] addr, input logic [7:0] len,
                            input logic [31:0] base);
        int err = 0;
        int n = int'(len) + 1;
        chk({nm, " aw_count"}, aw_n - s_aw, 1);
        chk({nm, " aw_addr"}, aw_addr_s, addr);
        chk({nm, " aw_len"}, aw_len_s, len);
        chk({nm, " beats"}, wbeats - s_wb, n);
        for (int i = 0; i < n; i++)
            if (wdat[(s_wb + i) % 4096] !== base + 32'(i)) err++;
        chk({nm, " data_errs"}, err, 0);
        chk({nm, " last_count"}, last_n - s_ln, 1);
        chk({nm, " last_beat"}, last_at - s_wb, n - 1);
        chk({nm, " early_data"}, early - s_early, 0);
        chk({nm, " strb_errs"}, strb_err - s_strb, 0);
    endtask

    typedef struct {
        logic [7:0]  op;
        logic [15:0] mid;
        logic [7:0]  len;
        int          ndata;
        logic [27:0] addr;
        logic [31:0] base;
        bit          same_done;
        bit          ok;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int err;
        logic [31:0] exp_w;
        logic pv, pr;
        logic [31:0] pd;

        vecs[0] = '{8'h01, 16'h0000, 8'hFF, 256, 28'h0,       32'h0,        1'b0, 1'b1};
        vecs[1] = '{8'h01, 16'hBEEF, 8'h00, 1,   28'h1234567, 32'hCAFE0000, 1'b1, 1'b1};
        vecs[2] = '{8'h05, 16'h0000, 8'h00, 0,   28'h0,       32'h0,        1'b0, 1'b0};
        vecs[3] = '{8'h01, 16'h0000, 8'h00, 0,   28'h10,      32'h0,        1'b0, 1'b0};
        vecs[4] = '{8'h01, 16'h0000, 8'h03, 2,   28'h20,      32'h100,      1'b0, 1'b0};
        vecs[5] = '{8'h01, 16'h0000, 8'h03, 4,   28'hABCDEF0, 32'h5000,     1'b0, 1'b1};
        vecs[6] = '{8'h02, 16'h0000, 8'h00, 1,   28'h0,       32'h0,        1'b0, 1'b0};
        vecs[7] = '{8'h01, 16'h0000, 8'h01, 3,   28'h30,      32'h0,        1'b1, 1'b0};

        tick(); tick();
        chk("rst_wr", {wr_addr, wr_len, wr_addr_valid, wr_data_valid, wr_data_last}, 0);
        chk("rst_wdata", wr_data, 0);
        chk("rst_rd", {rd_addr, rd_len, rd_addr_valid, rd_data_ready, tx_start_en}, 0);
        chk("rst_tx", udp_tx_data, 0);
        chk("rst_strb", wr_strb, 4'hF);
        rst = 1'b0;
        tick();

        for (int v = 0; v < 8; v++) begin
            snap();
            build(vecs[v].op, vecs[v].mid, vecs[v].len, vecs[v].ndata, vecs[v].addr, vecs[v].base);
            send_pkt(vecs[v].same_done);
            if (vecs[v].ok) begin
                wait_beats(s_wb + int'(vecs[v].len) + 1, 400);
                tick(); tick();
                check_wr($sformatf("vec%0d", v), vecs[v].addr, vecs[v].len, vecs[v].base);
                chk($sformatf("vec%0d idle", v), wr_data_valid, 0);
            end else begin
                repeat (30) tick();
                chk($sformatf("vec%0d dropped", v), anyv - s_anyv, 0);
            end
        end

        // Read back 256 beats, then return them with gapped tx_req.
        snap();
        build(8'h02, 16'h0, 8'hFF, 0, 28'h0, 32'h0);
        send_pkt(1'b0);
        for (int k = 0; k < 10 && !rd_addr_valid; k++) tick();
        err = 0;
        for (int k = 0; k < 3; k++) begin
            if (!rd_addr_valid || rd_addr !== 28'h0 || rd_len !== 8'hFF) err++;
            tick();
        end
        chk("rd ar_hold", err, 0);
        rd_addr_ready = 1'b1; tick(); rd_addr_ready = 1'b0;
        chk("rd ar_count", ar_n - s_ar, 1);
        chk("rd ar_len", ar_len_s, 8'hFF);
        chk("rd ar_addr", ar_addr_s, 28'h0);
        err = 0;
        for (int i = 0; i < 256; i++) begin
            if (i == 10) begin rd_data_valid = 1'b0; tick(); end
            rd_data_valid = 1'b1; rd_data = 32'(i); rd_data_last = (i == 255);
            if (!rd_data_ready) err++;
            tick();
        end
        rd_data_valid = 1'b0; rd_data_last = 1'b0;
        chk("rd ready_errs", err, 0);
        chk("rd ready_drop", rd_data_ready, 0);
        chk("tx_start pulse", tx_start_en, 1);
        tick();
        chk("tx_start single", tx_start_en, 0);
        err = 0;
        for (int i = 0; i < 257; i++) begin
            exp_w = (i == 0) ? 32'h020000FF : 32'(i - 1);
            tx_req = 1'b1; tick(); tx_req = 1'b0;
            if (udp_tx_data !== exp_w) err++;
            tick();
            if (udp_tx_data !== exp_w) err++;
        end
        chk("tx data_errs", err, 0);
        tx_req = 1'b1; tick(); tick(); tx_req = 1'b0;
        chk("tx idle_hold", udp_tx_data, 32'h000000FF);
        chk("tx start_count", txs_n - s_txs, 1);

        // Address backpressure for 10 cycles, then data ready toggling.
        snap();
        wr_addr_ready = 1'b0;
        build(8'h01, 16'h0, 8'h03, 4, 28'h55, 32'hA0);
        send_pkt(1'b0);
        err = 0;
        for (int k = 0; k < 10; k++) begin
            if (!wr_addr_valid || wr_addr !== 28'h55 || wr_len !== 8'h03 || wr_data_valid) err++;
            tick();
        end
        chk("bp aw_hold", err, 0);
        wr_addr_ready = 1'b1; tick(); wr_addr_ready = 1'b0;
        chk("bp aw_drop", wr_addr_valid, 0);
        wr_data_ready = 1'b0;
        err = 0;
        for (int k = 0; k < 40 && wbeats < s_wb + 4; k++) begin
            pv = wr_data_valid; pr = wr_data_ready; pd = wr_data;
            tick();
            if (pv && !pr && (!wr_data_valid || wr_data !== pd)) err++;
            wr_data_ready = ~wr_data_ready;
        end
        wr_data_ready = 1'b1; wr_addr_ready = 1'b1;
        tick(); tick();
        chk("bp w_hold", err, 0);
        check_wr("bp", 28'h55, 8'h03, 32'hA0);

        // Second packet during WR_DATA must be ignored.
        snap();
        wr_data_ready = 1'b0;
        build(8'h01, 16'h0, 8'h07, 8, 28'h77, 32'h700);
        send_pkt(1'b0);
        for (int k = 0; k < 10 && !wr_data_valid; k++) tick();
        build(8'h02, 16'h0, 8'h00, 0, 28'h99, 32'h0);
        send_pkt(1'b0);
        wr_data_ready = 1'b1;
        wait_beats(s_wb + 8, 50);
        repeat (20) tick();
        check_wr("busy", 28'h77, 8'h07, 32'h700);
        chk("busy no_read", ar_n - s_ar, 0);

        // Asynchronous reset in the middle of a write burst.
        build(8'h01, 16'h0, 8'h0F, 16, 28'hDD, 32'hD00);
        send_pkt(1'b0);
        repeat (5) tick();
        #3 rst = 1'b1;
        #1;
        chk("mid_rst valids", {wr_addr_valid, wr_data_valid, wr_data_last, rd_addr_valid,
                               rd_data_ready, tx_start_en}, 0);
        chk("mid_rst strb", wr_strb, 4'hF);
        chk("mid_rst addr", wr_addr, 0);
        tick();
        rst = 1'b0;
        tick();
        snap();
        build(8'h01, 16'h0, 8'h01, 2, 28'hE0E, 32'hE0);
        send_pkt(1'b0);
        wait_beats(s_wb + 2, 30);
        tick(); tick();
        check_wr("post_rst", 28'hE0E, 8'h01, 32'hE0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
